mips32_prog_loader: RTL



---
 rtl/mips32_pkg.sv | 29 ++
 rtl/mips32_prog_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 core and its program loader:
// special instruction words, the opcode field and the loader state encoding.
package mips32_pkg;

  localparam logic [31:0] NOP_WORD   = 32'h0ce77800;
  localparam logic [31:0] HLT_WORD   = 32'hfc000000;
  localparam logic [5:0]  OP_HLT     = 6'h3f;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_SEAL,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic is_hlt(input logic [31:0] word);
    return opcode(word) == OP_HLT;
  endfunction

endpackage

// File: rtl/mips32_prog_loader.sv
// Streams a program into the mips32 instruction memory, optionally padding
// with NOPs and sealing with HLT, then runs the core until it halts.
module mips32_prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter bit PAD_NOP = 1'b1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  input  logic              halted,
  output logic              done,
  output logic              err_ovf,
  output logic [ADDR_W:0]   word_count
);

  import mips32_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);

  loader_state_e r_state;
  loader_state_e w_next_state;

  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_last_seen;
  logic              r_last_hlt;
  logic              r_s_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_run;
  logic              r_done;
  logic              r_err_ovf;

  logic              w_full;
  logic              w_hs;
  logic              w_write;
  logic [31:0]       w_wdata;
  logic              w_restart;
  logic [ADDR_W:0]   w_next_addr;

  assign w_full = (r_addr == DEPTH_L);
  assign w_hs   = (r_state == ST_LOAD) && s_valid && r_s_ready;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Every memory write (data, pad, seal) funnels through w_write so that the
  // overflow check and the address increment live in exactly one place.
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_wdata      = '0;
    w_restart    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_next_state = ST_LOAD;
          w_restart    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (s_valid && w_full) begin
          w_next_state = ST_ERR;
        end else if (w_hs) begin
          w_write = 1'b1;
          w_wdata = s_data;
          if (PAD_NOP && !is_hlt(s_data)) begin
            w_next_state = ST_PAD;
          end else if (s_last) begin
            w_next_state = ST_SEAL;
          end
        end
      end
      ST_PAD: begin
        if (w_full) begin
          w_next_state = ST_ERR;
        end else begin
          w_write      = 1'b1;
          w_wdata      = NOP_WORD;
          w_next_state = r_last_seen ? ST_SEAL : ST_LOAD;
        end
      end
      ST_SEAL: begin
        if (r_last_hlt) begin
          w_next_state = ST_RUN;
        end else if (w_full) begin
          w_next_state = ST_ERR;
        end else begin
          w_write      = 1'b1;
          w_wdata      = HLT_WORD;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halted) begin
          w_next_state = ST_DONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_next_addr = r_addr;
    if (w_restart) begin
      w_next_addr = '0;
    end else if (w_write) begin
      w_next_addr = r_addr + ADDR_ONE;
    end
  end

  // s_ready is computed from next state and next address so that it is
  // already low on the cycle the loader cannot take another word.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_word_count <= '0;
      r_last_seen  <= 1'b0;
      r_last_hlt   <= 1'b0;
      r_s_ready    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_run   <= 1'b0;
      r_done       <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_addr     <= w_next_addr;
      r_mem_we   <= w_write;
      r_s_ready  <= (w_next_state == ST_LOAD) && (w_next_addr != DEPTH_L);
      r_core_run <= (w_next_state == ST_RUN);

      if (w_write) begin
        r_mem_addr  <= r_addr[ADDR_W-1:0];
        r_mem_wdata <= w_wdata;
      end

      if (w_restart) begin
        r_word_count <= '0;
      end else if (w_write && (r_word_count != DEPTH_L)) begin
        r_word_count <= r_word_count + ADDR_ONE;
      end

      if (w_hs) begin
        r_last_seen <= s_last;
        r_last_hlt  <= is_hlt(s_data);
      end

      if (w_restart) begin
        r_done    <= 1'b0;
        r_err_ovf <= 1'b0;
      end else begin
        if ((r_state == ST_RUN) && (w_next_state == ST_DONE)) begin
          r_done <= 1'b1;
        end
        if (w_next_state == ST_ERR) begin
          r_err_ovf <= 1'b1;
        end
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_run   = r_core_run;
  assign done       = r_done;
  assign err_ovf    = r_err_ovf;
  assign word_count = r_word_count;

endmodule
